step_dir_input: RTL

STEP_DIR_INPUT -- requirements
Module: step_dir_input

---
 rtl/step_dir_input.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/step_dir_input.sv
// step_dir_input: synchronizes and filters external STEP/DIR/EN pins,
// emits one step pulse per accepted edge and tracks signed position.
module step_dir_input #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int MIN_PERIOD    = 16,
  parameter int POS_WIDTH     = 32
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 STEPINPUT,
  input  logic                 DIRINPUT,
  input  logic                 ENINPUT,
  input  logic                 clear_pos,
  input  logic                 fault_clear,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 enable_out,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_fault
);

  localparam int FW  = $clog2(FILTER_CYCLES + 1);
  localparam int PCW = $clog2(MIN_PERIOD + 1);
  localparam int S   = SYNC_STAGES;

  localparam logic [FW-1:0]  FLT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [PCW-1:0] PER_MAX  = PCW'(MIN_PERIOD);
  localparam logic [POS_WIDTH-1:0] POS_ONE =
    {{(POS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    UNARMED,
    ARMED,
    HIGH
  } state_t;

  logic [S-1:0]   step_sync;
  logic [S-1:0]   dir_sync;
  logic [S-1:0]   en_sync;
  logic [S-1:0]   sync_vld;
  logic [FW-1:0]  step_cnt;
  logic [FW-1:0]  dir_cnt;
  logic           step_filt;
  logic           dir_filt;
  logic [PCW-1:0] period;
  logic           accept;
  state_t         state;
  state_t         state_nx;

  logic step_s;
  logic dir_s;
  logic primed;

  assign step_s     = step_sync[S-1];
  assign dir_s      = dir_sync[S-1];
  assign primed     = sync_vld[S-1];
  assign enable_out = en_sync[S-1];
  assign dir_out    = dir_filt;

  // Pin synchronizers; sync_vld marks when the chain holds real pin data.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      step_sync <= '0;
      dir_sync  <= '0;
      en_sync   <= '0;
      sync_vld  <= '0;
    end else begin
      step_sync <= {step_sync[S-2:0], STEPINPUT};
      dir_sync  <= {dir_sync[S-2:0], DIRINPUT};
      en_sync   <= {en_sync[S-2:0], ENINPUT};
      sync_vld  <= {sync_vld[S-2:0], 1'b1};
    end
  end

  // Level filters: flip only after a full run of mismatching samples.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      step_cnt  <= '0;
      dir_cnt   <= '0;
      step_filt <= 1'b0;
      dir_filt  <= 1'b0;
    end else begin
      if (step_s == step_filt) begin
        step_cnt <= '0;
      end else if (step_cnt == FLT_LAST) begin
        step_cnt  <= '0;
        step_filt <= step_s;
      end else begin
        step_cnt <= step_cnt + FW'(1);
      end
      if (dir_s == dir_filt) begin
        dir_cnt <= '0;
      end else if (dir_cnt == FLT_LAST) begin
        dir_cnt  <= '0;
        dir_filt <= dir_s;
      end else begin
        dir_cnt <= dir_cnt + FW'(1);
      end
    end
  end

  // Step state register.
  always_ff @(posedge CLK) begin
    if (!resetn) state <= UNARMED;
    else         state <= state_nx;
  end

  // Arming waits for a genuine low so a pin held high at reset is ignored.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      UNARMED: begin
        if (primed && !step_s && !step_filt)
          state_nx = ARMED;
      end
      ARMED: begin
        if (step_filt) begin
          state_nx = HIGH;
          accept   = enable_out;
        end
      end
      HIGH: begin
        if (!step_filt)
          state_nx = ARMED;
      end
      default: state_nx = UNARMED;
    endcase
  end

  // Step pulse, position, period counter and sticky fault.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      step_out   <= 1'b0;
      position   <= '0;
      step_fault <= 1'b0;
      period     <= PER_MAX;
    end else begin
      step_out <= accept;
      if (clear_pos)
        position <= '0;
      else if (step_out)
        position <= dir_out ? position + POS_ONE
                            : position - POS_ONE;
      if (step_out && period < PER_MAX)
        step_fault <= 1'b1;
      else if (fault_clear)
        step_fault <= 1'b0;
      if (step_out)
        period <= '0;
      else if (period < PER_MAX)
        period <= period + PCW'(1);
    end
  end

endmodule
